// File: rtl/hs_lock_aligner.sv
// hs_lock_aligner
// Finds the 64b/66b sync-header offset in the gearbox receive buffer.
// NUM_SEEKERS parallel seekers each scan a contiguous slice of the NUM_POS
// candidate offsets with a HUNT/VERIFY/LOCKED state machine. A sticky
// registered arbiter reports one locked seeker downstream.
//
// Ports:
//   clk_i       in   system clock
//   rst_i       in   synchronous active-high reset
//   gbox_buffer in   gearbox buffer view, BUF_W bits
//   buffer_dv   in   gbox_buffer holds a new frame this cycle
//   is_synced   out  reported offset belongs to a locked seeker
//   offset_pos  out  offset of the selected seeker (holds when unsynced)
//   winner_idx  out  index of the selected seeker (holds when unsynced)
//   locked_vec  out  per-seeker LOCKED flags, same pipeline stage as is_synced
//   lock_lost   out  one-cycle pulse the cycle after is_synced falls
module hs_lock_aligner #(
  parameter int BUF_W       = 194,
  parameter int NUM_POS     = 66,
  parameter int NUM_SEEKERS = 4,
  parameter int LOCK_CNT    = 4,
  parameter int WIN_LEN     = 16,
  parameter int BAD_MAX     = 4,
  // Derived widths; leave at their defaults.
  parameter int POS_W       = $clog2(NUM_POS),
  parameter int IDX_W       = (NUM_SEEKERS > 1) ? $clog2(NUM_SEEKERS) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [BUF_W-1:0]       gbox_buffer,
  input  logic                   buffer_dv,
  output logic                   is_synced,
  output logic [POS_W-1:0]       offset_pos,
  output logic [IDX_W-1:0]       winner_idx,
  output logic [NUM_SEEKERS-1:0] locked_vec,
  output logic                   lock_lost
);

  localparam int BIDX_W = $clog2(BUF_W);
  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int WIN_W  = $clog2(WIN_LEN + 1);
  localparam int BAD_W  = $clog2(BAD_MAX + 1);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // A sync header is valid only when its two bits differ (01 or 10).
  function automatic logic hdr_valid(input logic [1:0] hdr);
    return hdr[1] ^ hdr[0];
  endfunction

  logic [NUM_SEEKERS-1:0] w_locked;
  logic [POS_W-1:0]       w_pos_all [NUM_SEEKERS];

  for (genvar k = 0; k < NUM_SEEKERS; k++) begin : g_seeker
    localparam logic [POS_W-1:0] BASE = POS_W'((k * NUM_POS) / NUM_SEEKERS);
    localparam logic [POS_W-1:0] LAST = POS_W'(((k + 1) * NUM_POS) / NUM_SEEKERS - 1);

    state_t            r_state, w_state_nxt;
    logic [POS_W-1:0]  r_pos, w_pos_nxt, w_pos_slip;
    logic [GOOD_W-1:0] r_good, w_good_nxt, w_good_inc;
    logic [WIN_W-1:0]  r_win, w_win_nxt, w_win_inc;
    logic [BAD_W-1:0]  r_bad, w_bad_nxt, w_bad_inc;
    logic [BIDX_W-1:0] w_hdr_idx;
    logic              w_hdr_ok;

    assign w_hdr_idx  = BIDX_W'(r_pos);
    assign w_hdr_ok   = hdr_valid(gbox_buffer[w_hdr_idx +: 2]);
    // Slip wraps inside this seeker's own slice only.
    assign w_pos_slip = (r_pos == LAST) ? BASE : (r_pos + POS_W'(1));
    assign w_good_inc = r_good + GOOD_W'(1);
    assign w_win_inc  = r_win + WIN_W'(1);
    assign w_bad_inc  = r_bad + (w_hdr_ok ? BAD_W'(0) : BAD_W'(1));

    assign w_locked[k]  = (r_state == ST_LOCKED);
    assign w_pos_all[k] = r_pos;

    // Seeker state, position and counters.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_state <= ST_HUNT;
        r_pos   <= BASE;
        r_good  <= GOOD_W'(0);
        r_win   <= WIN_W'(0);
        r_bad   <= BAD_W'(0);
      end else begin
        r_state <= w_state_nxt;
        r_pos   <= w_pos_nxt;
        r_good  <= w_good_nxt;
        r_win   <= w_win_nxt;
        r_bad   <= w_bad_nxt;
      end
    end

    // Seeker next-state: only frames with buffer_dv advance anything.
    always_comb begin
      w_state_nxt = r_state;
      w_pos_nxt   = r_pos;
      w_good_nxt  = r_good;
      w_win_nxt   = r_win;
      w_bad_nxt   = r_bad;
      if (buffer_dv) begin
        case (r_state)
          ST_HUNT: begin
            if (w_hdr_ok) begin
              w_good_nxt  = GOOD_W'(1);
              w_win_nxt   = WIN_W'(0);
              w_bad_nxt   = BAD_W'(0);
              w_state_nxt = (LOCK_CNT == 1) ? ST_LOCKED : ST_VERIFY;
            end else begin
              w_pos_nxt = w_pos_slip;
            end
          end
          ST_VERIFY: begin
            if (w_hdr_ok) begin
              w_good_nxt = w_good_inc;
              if (w_good_inc == GOOD_W'(LOCK_CNT)) begin
                w_state_nxt = ST_LOCKED;
                w_win_nxt   = WIN_W'(0);
                w_bad_nxt   = BAD_W'(0);
              end else begin
                w_state_nxt = ST_VERIFY;
              end
            end else begin
              w_pos_nxt   = w_pos_slip;
              w_good_nxt  = GOOD_W'(0);
              w_state_nxt = ST_HUNT;
            end
          end
          ST_LOCKED: begin
            // Unlock wins over a window rollover on the same frame.
            if (w_bad_inc == BAD_W'(BAD_MAX)) begin
              w_pos_nxt   = w_pos_slip;
              w_good_nxt  = GOOD_W'(0);
              w_win_nxt   = WIN_W'(0);
              w_bad_nxt   = BAD_W'(0);
              w_state_nxt = ST_HUNT;
            end else if (w_win_inc == WIN_W'(WIN_LEN)) begin
              w_win_nxt = WIN_W'(0);
              w_bad_nxt = BAD_W'(0);
            end else begin
              w_win_nxt = w_win_inc;
              w_bad_nxt = w_bad_inc;
            end
          end
          default: begin
            w_state_nxt = ST_HUNT;
            w_pos_nxt   = BASE;
            w_good_nxt  = GOOD_W'(0);
            w_win_nxt   = WIN_W'(0);
            w_bad_nxt   = BAD_W'(0);
          end
        endcase
      end else begin
        w_state_nxt = r_state;
      end
    end
  end

  logic                   r_synced, r_synced_d, r_lost;
  logic [IDX_W-1:0]       r_winner;
  logic [POS_W-1:0]       r_offset;
  logic [NUM_SEEKERS-1:0] r_locked_vec;
  logic                   w_any_locked;
  logic [IDX_W-1:0]       w_low_idx;
  logic                   w_synced_nxt;
  logic [IDX_W-1:0]       w_winner_nxt;
  logic [POS_W-1:0]       w_offset_nxt;

  assign w_any_locked = |w_locked;

  // Lowest-index locked seeker; scanning downward lets lower indices win.
  always_comb begin
    w_low_idx = {IDX_W{1'b0}};
    for (int k = NUM_SEEKERS - 1; k >= 0; k--) begin
      if (w_locked[k]) begin
        w_low_idx = IDX_W'(k);
      end else begin
        w_low_idx = w_low_idx;
      end
    end
  end

  // Sticky arbitration: keep the current winner while it stays locked.
  always_comb begin
    w_synced_nxt = r_synced;
    w_winner_nxt = r_winner;
    w_offset_nxt = r_offset;
    if (w_locked[r_winner]) begin
      w_synced_nxt = 1'b1;
      w_offset_nxt = w_pos_all[r_winner];
    end else if (w_any_locked) begin
      w_synced_nxt = 1'b1;
      w_winner_nxt = w_low_idx;
      w_offset_nxt = w_pos_all[w_low_idx];
    end else begin
      w_synced_nxt = 1'b0;
    end
  end

  // Output registers; lock_lost fires one cycle after is_synced drops.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_synced     <= 1'b0;
      r_synced_d   <= 1'b0;
      r_lost       <= 1'b0;
      r_winner     <= {IDX_W{1'b0}};
      r_offset     <= {POS_W{1'b0}};
      r_locked_vec <= {NUM_SEEKERS{1'b0}};
    end else begin
      r_synced     <= w_synced_nxt;
      r_synced_d   <= r_synced;
      r_lost       <= r_synced_d & ~r_synced;
      r_winner     <= w_winner_nxt;
      r_offset     <= w_offset_nxt;
      r_locked_vec <= w_locked;
    end
  end

  assign is_synced  = r_synced;
  assign offset_pos = r_offset;
  assign winner_idx = r_winner;
  assign locked_vec = r_locked_vec;
  assign lock_lost  = r_lost;

endmodule

// File: tb/tb_hs_lock_aligner.sv
// Self-checking bench for hs_lock_aligner with default parameters.
// Buffers are built as a single band of ones in bits [lo..hi]; with lo>hi the
// buffer is all zeros. A band starting at lo makes offset lo-1 the only valid
// header below it ({1,0}) and offset hi valid above it ({0,1}).
module tb_hs_lock_aligner;
  localparam int BUF_W       = 194;
  localparam int NUM_SEEKERS = 4;
  localparam int POS_W       = 7;
  localparam int IDX_W       = 2;

  logic                   clk_i = 1'b0;
  logic                   rst_i;
  logic [BUF_W-1:0]       gbox_buffer;
  logic                   buffer_dv;
  logic                   is_synced;
  logic [POS_W-1:0]       offset_pos;
  logic [IDX_W-1:0]       winner_idx;
  logic [NUM_SEEKERS-1:0] locked_vec;
  logic                   lock_lost;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  hs_lock_aligner dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .gbox_buffer (gbox_buffer),
    .buffer_dv   (buffer_dv),
    .is_synced   (is_synced),
    .offset_pos  (offset_pos),
    .winner_idx  (winner_idx),
    .locked_vec  (locked_vec),
    .lock_lost   (lock_lost)
  );

  typedef struct {
    logic       rst;
    logic       dv;
    int         lo;
    int         hi;
    logic       exp_sync;
    int         exp_off;
    int         exp_idx;
    logic [3:0] exp_lv;
    logic       exp_lost;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [BUF_W-1:0] band(input int lo, input int hi);
    logic [BUF_W-1:0] b;
    b = {BUF_W{1'b0}};
    for (int i = 0; i < BUF_W; i++) begin
      if (i >= lo && i <= hi) b[i] = 1'b1;
    end
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the edge.
  task automatic tick(input logic rst, input logic dv, input int lo, input int hi);
    rst_i       = rst;
    buffer_dv   = dv;
    gbox_buffer = band(lo, hi);
    @(posedge clk_i);
    #1;
  endtask

  task automatic add(input logic rst, input logic dv, input int lo, input int hi,
                     input logic es, input int eo, input int ei,
                     input logic [3:0] elv, input logic el);
    vec_t v;
    v.rst = rst; v.dv = dv; v.lo = lo; v.hi = hi;
    v.exp_sync = es; v.exp_off = eo; v.exp_idx = ei; v.exp_lv = elv; v.exp_lost = el;
    vecs.push_back(v);
  endtask

  initial begin
    rst_i       = 1'b1;
    buffer_dv   = 1'b0;
    gbox_buffer = {BUF_W{1'b0}};

    // Single valid offset 20: seeker1 slips 16->20, locks on frame 8.
    add(1'b1, 1'b0, 1, 0, 1'b0, 0, 0, 4'b0000, 1'b0);
    for (int f = 1; f <= 8; f++) add(1'b0, 1'b1, 21, 193, 1'b0, 0, 0, 4'b0000, 1'b0);
    add(1'b0, 1'b1, 21, 193, 1'b1, 20, 1, 4'b0010, 1'b0);
    add(1'b0, 1'b1, 21, 193, 1'b1, 20, 1, 4'b0010, 1'b0);
    // Offsets 5 and 40: seeker0 locks frame 9, seeker2 frame 11.
    add(1'b1, 1'b0, 1, 0, 1'b0, 0, 0, 4'b0000, 1'b0);
    for (int f = 1; f <= 9; f++) add(1'b0, 1'b1, 6, 40, 1'b0, 0, 0, 4'b0000, 1'b0);
    add(1'b0, 1'b1, 6, 40, 1'b1, 5, 0, 4'b0001, 1'b0);
    add(1'b0, 1'b1, 6, 40, 1'b1, 5, 0, 4'b0001, 1'b0);
    add(1'b0, 1'b1, 6, 40, 1'b1, 5, 0, 4'b0101, 1'b0);
    // Offset 5 goes bad on frames 13..16; seeker0 drops, winner moves to 2.
    for (int f = 13; f <= 16; f++) add(1'b0, 1'b1, 0, 40, 1'b1, 5, 0, 4'b0101, 1'b0);
    add(1'b0, 1'b1, 0, 40, 1'b1, 40, 2, 4'b0100, 1'b0);
    add(1'b0, 1'b1, 0, 40, 1'b1, 40, 2, 4'b0100, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      tick(vecs[i].rst, vecs[i].dv, vecs[i].lo, vecs[i].hi);
      chk($sformatf("v%0d.sync", i), is_synced, vecs[i].exp_sync);
      chk($sformatf("v%0d.off", i), offset_pos, vecs[i].exp_off);
      chk($sformatf("v%0d.idx", i), winner_idx, vecs[i].exp_idx);
      chk($sformatf("v%0d.lv", i), locked_vec, vecs[i].exp_lv);
      chk($sformatf("v%0d.lost", i), lock_lost, vecs[i].exp_lost);
    end

    // Hysteresis: 3 bad per 16-frame window (6 in a row across one boundary)
    // holds lock; 4 bad in the sixth window (frames 89..92) drops it.
    tick(1'b1, 1'b0, 1, 0);
    for (int f = 1; f <= 8; f++) tick(1'b0, 1'b1, 21, 193);
    for (int f = 9; f <= 92; f++) begin
      int w;
      int o;
      logic bad;
      w = (f - 9) / 16;
      o = (f - 9) % 16;
      bad = (w == 5) ? (o <= 3) : (((w % 2) == 0) ? (o >= 13) : (o <= 2));
      if (bad) tick(1'b0, 1'b1, 1, 0);
      else     tick(1'b0, 1'b1, 21, 193);
      chk($sformatf("hyst.sync.f%0d", f), is_synced, 1);
      chk($sformatf("hyst.lost.f%0d", f), lock_lost, 0);
    end
    tick(1'b0, 1'b0, 1, 0);
    chk("hyst.fall.sync", is_synced, 0);
    chk("hyst.fall.lost", lock_lost, 0);
    chk("hyst.fall.lv", locked_vec, 0);
    tick(1'b0, 1'b0, 1, 0);
    chk("hyst.pulse.lost", lock_lost, 1);
    chk("hyst.pulse.sync", is_synced, 0);
    tick(1'b0, 1'b0, 1, 0);
    chk("hyst.pulse_end.lost", lock_lost, 0);
    // Seeker1 must be parked at 21: only offset 21 is valid, lock in 4 frames.
    for (int f = 1; f <= 5; f++) begin
      tick(1'b0, 1'b1, 22, 193);
      chk($sformatf("hyst.relock.f%0d", f), is_synced, (f == 5) ? 1 : 0);
    end
    chk("hyst.relock.off", offset_pos, 21);
    chk("hyst.relock.idx", winner_idx, 1);

    // Wrap-around: seeker0 wraps 15->0 and locks at 4 on frame 24.
    tick(1'b1, 1'b0, 1, 0);
    for (int f = 1; f <= 20; f++) tick(1'b0, 1'b1, 1, 0);
    for (int f = 21; f <= 25; f++) begin
      tick(1'b0, 1'b1, 5, 193);
      chk($sformatf("wrap.sync.f%0d", f), is_synced, (f == 25) ? 1 : 0);
    end
    chk("wrap.off", offset_pos, 4);
    chk("wrap.idx", winner_idx, 0);

    // dv gaps: lock counts dv frames only.
    tick(1'b1, 1'b0, 1, 0);
    for (int fr = 1; fr <= 8; fr++) begin
      tick(1'b0, 1'b1, 21, 193);
      chk($sformatf("gap.dv.f%0d", fr), is_synced, 0);
      for (int g = 0; g < 3; g++) begin
        tick(1'b0, 1'b0, 21, 193);
        chk($sformatf("gap.idle.f%0d.g%0d", fr, g), is_synced, (fr == 8) ? 1 : 0);
      end
    end
    chk("gap.off", offset_pos, 20);
    // Reset while locked, with buffer_dv high.
    tick(1'b1, 1'b1, 21, 193);
    chk("rstlock.sync", is_synced, 0);
    chk("rstlock.off", offset_pos, 0);
    chk("rstlock.idx", winner_idx, 0);
    chk("rstlock.lv", locked_vec, 0);
    chk("rstlock.lost", lock_lost, 0);

    // Reset mid-VERIFY: 4 slips + 2 good frames, then reset.
    tick(1'b1, 1'b0, 1, 0);
    for (int f = 1; f <= 6; f++) tick(1'b0, 1'b1, 21, 193);
    tick(1'b1, 1'b1, 21, 193);
    chk("rstver.sync", is_synced, 0);
    chk("rstver.off", offset_pos, 0);
    chk("rstver.idx", winner_idx, 0);
    chk("rstver.lv", locked_vec, 0);
    chk("rstver.lost", lock_lost, 0);
    for (int f = 1; f <= 9; f++) begin
      tick(1'b0, 1'b1, 21, 193);
      chk($sformatf("rstver.relock.f%0d", f), is_synced, (f == 9) ? 1 : 0);
    end
    chk("rstver.relock.off", offset_pos, 20);
    chk("rstver.relock.idx", winner_idx, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
